// File: rtl/alu_exec_stage_if.sv
// Handshake and data bundle between the decoder-driven producer and alu_exec_stage.
// The master modport belongs to the producer/consumer side; the slave modport belongs to the stage.
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_onehot;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             illegal;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, op_onehot, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, ovf, illegal, op_count
  );

  modport slave (
    input  in_valid, op_onehot, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, ovf, illegal, op_count
  );
endinterface

// File: rtl/alu_exec_stage.sv
// One-deep registered ALU execute stage (ADD/SUB/AND/OR) with a valid/ready handshake.
// Define ALU_FLAGS_EN to build the carry/borrow and signed-overflow flags; otherwise they tie to 0.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  alu_exec_stage_if.slave bus
);

`ifdef ALU_FLAGS_EN
  localparam int unsigned AW = WIDTH + 1;
`else
  localparam int unsigned AW = WIDTH;
`endif

  logic [AW-1:0]    sum;
  logic [AW-1:0]    diff;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             illegal_d, illegal_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] op_count_q;
  logic             in_ready;
  logic             accept;

  // Combinational ready lets a held result drain and a new one load in the same cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign sum  = AW'(bus.a) + AW'(bus.b);
  assign diff = AW'(bus.a) - AW'(bus.b);

  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    unique case (bus.op_onehot)
      4'b1000: result_d = sum[WIDTH-1:0];
      4'b0100: result_d = diff[WIDTH-1:0];
      4'b0010: result_d = bus.a & bus.b;
      4'b0001: result_d = bus.a | bus.b;
      default: illegal_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
  end

`ifdef ALU_FLAGS_EN
  logic carry_d, carry_q;
  logic ovf_d, ovf_q;

  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (bus.op_onehot)
      4'b1000: begin
        carry_d = sum[WIDTH];
        ovf_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0100: begin
        // diff[WIDTH] is the borrow out, set exactly when a < b unsigned.
        carry_d = diff[WIDTH];
        ovf_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
`else
  assign bus.carry = 1'b0;
  assign bus.ovf   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      op_count_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      op_count_q  <= op_count_q + CNT_W'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: expected results are queued at issue and popped at output.
module tb_alu_exec_stage;
  localparam int unsigned W = 8;
`ifdef ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         ill;
    logic [15:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  alu_exec_stage_if #(.WIDTH(W), .CNT_W(16)) bus ();
  alu_exec_stage_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

  alu_exec_stage #(.WIDTH(W), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_exec_stage #(.WIDTH(W), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model written in integer arithmetic, independent of the RTL bit tricks.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ua, ub, sa, sb_, r, s;
    int   m;
    m  = 1 << W;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb_ = (ub >= m / 2) ? ub - m : ub;
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    e.ill   = 1'b0;
    r = 0;
    case (op)
      4'b1000: begin
        r = ua + ub;
        e.carry = (r >= m);
        r = r % m;
        s = sa + sb_;
        e.ovf = (s > m / 2 - 1) || (s < -(m / 2));
      end
      4'b0100: begin
        e.carry = (ua < ub);
        r = (ua - ub + m) % m;
        s = sa - sb_;
        e.ovf = (s > m / 2 - 1) || (s < -(m / 2));
      end
      4'b0010: r = int'(a & b);
      4'b0001: r = int'(a | b);
      default: begin
        r = 0;
        e.ill = 1'b1;
      end
    endcase
    e.res   = W'(r);
    e.zero  = (r == 0);
    e.carry = e.carry & FLAGS;
    e.ovf   = e.ovf & FLAGS;
    e.cnt   = '0;
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.op_onehot = op;
    bus.a         = a;
    bus.b         = b;
    e             = model(op, a, b);
    exp_cnt       = (exp_cnt + 1) % 65536;
    e.cnt         = 16'(exp_cnt);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      last = e;
      check({tag, ".result"}, 32'(bus.result), 32'(e.res));
      check({tag, ".zero"}, 32'(bus.zero), 32'(e.zero));
      check({tag, ".carry"}, 32'(bus.carry), 32'(e.carry));
      check({tag, ".ovf"}, 32'(bus.ovf), 32'(e.ovf));
      check({tag, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
      check({tag, ".op_count"}, 32'(bus.op_count), 32'(e.cnt));
    end
  endtask

  // One accepted transfer with out_ready high; result is checked one cycle later.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    drive(op, a, b);
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    pop_check(tag);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.op_onehot  = 4'b0000;
    bus.a          = '0;
    bus.b          = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.op_onehot = 4'b1000;
    bus2.a         = 8'h01;
    bus2.b         = 8'h01;
    bus2.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", 32'(bus.result), 32'd0);
    check("rst.zero", 32'(bus.zero), 32'd0);
    check("rst.illegal", 32'(bus.illegal), 32'd0);
    check("rst.op_count", 32'(bus.op_count), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Arithmetic and logic ops back to back.
    issue("add_ovf", 4'b1000, 8'h7F, 8'h01);
    issue("sub_zero", 4'b0100, 8'h05, 8'h05);
    issue("sub_borrow", 4'b0100, 8'h03, 8'h05);
    issue("add_wrap", 4'b1000, 8'hFF, 8'h01);
    issue("and", 4'b0010, 8'hF0, 8'h3C);
    issue("or", 4'b0001, 8'hF0, 8'h3C);
    issue("sub_sovf", 4'b0100, 8'h80, 8'h01);

    // Drain with no new input: out_valid falls, data holds.
    bus.in_valid = 1'b0;
    step();
    check("drain.out_valid", 32'(bus.out_valid), 32'd0);
    check("drain.result", 32'(bus.result), 32'(last.res));

    // Backpressure: hold five cycles, then same-cycle drain and accept.
    bus.out_ready = 1'b0;
    drive(4'b1000, 8'h10, 8'h20);
    step();
    pop_check("bp_first");
    drive(4'b0001, 8'h0F, 8'hA0);
    for (int i = 0; i < 5; i++) begin
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check("bp.hold", 32'(bus.result), 32'(last.res));
      check("bp.op_count", 32'(bus.op_count), 32'(last.cnt));
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    step();
    pop_check("bp_second");

    // Illegal enables, then a legal op clears the flag.
    issue("ill_0000", 4'b0000, 8'h12, 8'h34);
    issue("ill_1100", 4'b1100, 8'h12, 8'h34);
    issue("legal_after", 4'b0010, 8'hFF, 8'h0F);

    // Reset coinciding with an accept discards it.
    issue("b2b_a", 4'b1000, 8'h01, 8'h02);
    bus.op_onehot = 4'b1000;
    bus.a         = 8'h05;
    bus.b         = 8'h06;
    bus.in_valid  = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    exp_cnt = 0;
    check("rst2.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst2.result", 32'(bus.result), 32'd0);
    check("rst2.zero", 32'(bus.zero), 32'd0);
    check("rst2.carry", 32'(bus.carry), 32'd0);
    check("rst2.ovf", 32'(bus.ovf), 32'd0);
    check("rst2.illegal", 32'(bus.illegal), 32'd0);
    check("rst2.op_count", 32'(bus.op_count), 32'd0);

    // Two-bit counter wraps after four accepts.
    bus2.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("cnt2.op_count", 32'(bus2.op_count), 32'(i % 4));
    end
    bus2.in_valid = 1'b0;
    step();
    check("cnt2.hold", 32'(bus2.op_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
